// File: rtl/uart_cmd_rx.sv
// UART 8N1 command receiver: deserialises bytes on uart_rxd, assembles {opcode, payload}
// packets and presents them one at a time over a valid/ready handshake.
module uart_cmd_rx #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rxd,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [7:0]            cmd_opcode,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned BYTES        = DATA_WIDTH / 8;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TO_CLKS      = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W         = $clog2(TO_CLKS + 1);
  localparam int unsigned IDX_W        = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_state_e;
  typedef enum logic       {A_OPC, A_PAYLOAD}                asm_state_e;

  // Input synchroniser and edge history
  logic rxd_meta_q, rxd_s_q, rxd_prev_q;

  // Bit-level receiver
  bit_state_e       bit_state_q, bit_state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_done_q, byte_done_d;
  logic             frame_err_q, frame_err_d;
  logic             start_c;

  // Packet assembler
  asm_state_e            asm_state_q, asm_state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            opc_buf_q, opc_buf_d;
  logic [DATA_WIDTH-1:0] data_buf_q, data_buf_d;
  logic [TO_W-1:0]       silence_q, silence_d;
  logic                  pkt_done_c;

  // Output register
  logic                  cmd_valid_q, cmd_valid_d;
  logic [7:0]            cmd_opcode_q, cmd_opcode_d;
  logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic                  overrun_q, overrun_d;
  logic                  accept_c;

  assign start_c  = (bit_state_q == S_IDLE) && rxd_prev_q && !rxd_s_q;
  assign accept_c = cmd_valid_q && cmd_ready;

  // Bit FSM: start detect, mid-bit sampling, stop-bit check
  always_comb begin
    bit_state_d = bit_state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    frame_err_d = 1'b0;
    unique case (bit_state_q)
      S_IDLE: begin
        if (start_c) begin
          bit_state_d = S_START;
          baud_cnt_d  = '0;
        end
      end
      S_START: begin
        if (baud_cnt_q == CNT_W'(HALF_BIT)) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          bit_state_d = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          baud_cnt_d = '0;
          shift_d    = {rxd_s_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) bit_state_d = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          baud_cnt_d  = '0;
          bit_state_d = S_IDLE;
          byte_done_d = rxd_s_q;
          frame_err_d = !rxd_s_q;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      default: bit_state_d = S_IDLE;
    endcase
  end

  // Assembler: opcode then BYTES payload bytes, abandoned on framing error or silence
  always_comb begin
    asm_state_d = asm_state_q;
    idx_d       = idx_q;
    opc_buf_d   = opc_buf_q;
    data_buf_d  = data_buf_q;
    silence_d   = silence_q;
    pkt_done_c  = 1'b0;
    if (frame_err_q) begin
      asm_state_d = A_OPC;
      silence_d   = '0;
    end else if (byte_done_q) begin
      silence_d = '0;
      if (asm_state_q == A_OPC) begin
        opc_buf_d   = shift_q;
        idx_d       = '0;
        asm_state_d = A_PAYLOAD;
      end else begin
        for (int i = 0; i < int'(BYTES); i++) begin
          if (idx_q == IDX_W'(i)) data_buf_d[8*i +: 8] = shift_q;
        end
        if (idx_q == IDX_W'(BYTES - 1)) begin
          pkt_done_c  = 1'b1;
          asm_state_d = A_OPC;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end else if (asm_state_q == A_PAYLOAD) begin
      if (start_c) begin
        silence_d = '0;
      end else if (bit_state_q == S_IDLE) begin
        if (silence_q == TO_W'(TO_CLKS - 1)) begin
          silence_d   = '0;
          asm_state_d = A_OPC;
        end else begin
          silence_d = silence_q + TO_W'(1);
        end
      end
    end else begin
      silence_d = '0;
    end
  end

  // Output holding register with overrun detection
  always_comb begin
    cmd_valid_d  = cmd_valid_q;
    cmd_opcode_d = cmd_opcode_q;
    cmd_data_d   = cmd_data_q;
    overrun_d    = 1'b0;
    if (pkt_done_c) begin
      if (!cmd_valid_q || accept_c) begin
        cmd_valid_d  = 1'b1;
        cmd_opcode_d = opc_buf_q;
        cmd_data_d   = data_buf_d;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept_c) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_prev_q   <= 1'b1;
      bit_state_q  <= S_IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      asm_state_q  <= A_OPC;
      idx_q        <= '0;
      opc_buf_q    <= '0;
      data_buf_q   <= '0;
      silence_q    <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= '0;
      cmd_data_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      rxd_meta_q   <= uart_rxd;
      rxd_s_q      <= rxd_meta_q;
      rxd_prev_q   <= rxd_s_q;
      bit_state_q  <= bit_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_done_q  <= byte_done_d;
      frame_err_q  <= frame_err_d;
      asm_state_q  <= asm_state_d;
      idx_q        <= idx_d;
      opc_buf_q    <= opc_buf_d;
      data_buf_q   <= data_buf_d;
      silence_q    <= silence_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_opcode_q <= cmd_opcode_d;
      cmd_data_q   <= cmd_data_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_opcode = cmd_opcode_q;
  assign cmd_data   = cmd_data_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit; expected values are hand-computed.
module tb_uart_cmd_rx;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        frame_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0]  last_op = '0;
  logic [31:0] last_data = '0;

  uart_cmd_rx #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_WIDTH(32), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Event monitor sampled away from the active edge
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      last_op   = cmd_opcode;
      last_data = cmd_data;
    end
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int bits);
    uart_rxd = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [31:0] d);
    send_byte(op, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  initial begin
    int acc0, fe0, ov0, n;

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_outputs", 64'({cmd_valid, frame_err, overrun, cmd_opcode, cmd_data}), 64'(0));
    reset = 1'b1;
    idle(2);

    // 1: basic packet with ready high
    cmd_ready = 1'b1;
    acc0 = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    send_pkt(8'h01, 32'h1234_5678);
    idle(3);
    check("t1_accepts", 64'(acc_cnt - acc0), 64'(1));
    check("t1_opcode", 64'(last_op), 64'(8'h01));
    check("t1_data", 64'(last_data), 64'(32'h1234_5678));
    check("t1_frame_err", 64'(fe_cnt - fe0), 64'(0));
    check("t1_overrun", 64'(ov_cnt - ov0), 64'(0));
    check("t1_valid_low", 64'(cmd_valid), 64'(0));

    // 2: bad stop bit on second byte, then a clean packet
    acc0 = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h78, 1'b0);
    idle(1);
    send_pkt(8'h02, 32'hDEAD_BEEF);
    idle(3);
    check("t2_frame_err", 64'(fe_cnt - fe0), 64'(1));
    check("t2_accepts", 64'(acc_cnt - acc0), 64'(1));
    check("t2_opcode", 64'(last_op), 64'(8'h02));
    check("t2_data", 64'(last_data), 64'(32'hDEAD_BEEF));
    check("t2_overrun", 64'(ov_cnt - ov0), 64'(0));

    // 3: backpressure, second packet overruns
    cmd_ready = 1'b0;
    acc0 = acc_cnt; ov0 = ov_cnt;
    send_pkt(8'h10, 32'h1122_3344);
    n = 0;
    while (!cmd_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t3_valid_a", 64'(cmd_valid), 64'(1));
    check("t3_opcode_a", 64'(cmd_opcode), 64'(8'h10));
    check("t3_data_a", 64'(cmd_data), 64'(32'h1122_3344));
    send_pkt(8'h20, 32'h5566_7788);
    idle(3);
    check("t3_overrun", 64'(ov_cnt - ov0), 64'(1));
    check("t3_hold_valid", 64'(cmd_valid), 64'(1));
    check("t3_hold_opcode", 64'(cmd_opcode), 64'(8'h10));
    check("t3_hold_data", 64'(cmd_data), 64'(32'h1122_3344));
    cmd_ready = 1'b1;
    @(negedge clk);
    check("t3_accepts", 64'(acc_cnt - acc0), 64'(1));
    check("t3_valid_low", 64'(cmd_valid), 64'(0));
    check("t3_retain_opcode", 64'(cmd_opcode), 64'(8'h10));
    check("t3_retain_data", 64'(cmd_data), 64'(32'h1122_3344));

    // 4: short low glitch on an idle line
    acc0 = acc_cnt; fe0 = fe_cnt;
    uart_rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    idle(3);
    check("t4_frame_err", 64'(fe_cnt - fe0), 64'(0));
    check("t4_accepts", 64'(acc_cnt - acc0), 64'(0));

    // 5: mid-packet silence abandons the partial packet
    acc0 = acc_cnt;
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(25);
    send_pkt(8'h04, 32'hDDCC_BBAA);
    idle(3);
    check("t5_accepts", 64'(acc_cnt - acc0), 64'(1));
    check("t5_opcode", 64'(last_op), 64'(8'h04));
    check("t5_data", 64'(last_data), 64'(32'hDDCC_BBAA));

    // 6: reset in the middle of a payload byte
    send_byte(8'h05, 1'b1);
    uart_rxd = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    reset = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_reset_outputs", 64'({cmd_valid, frame_err, overrun, cmd_opcode, cmd_data}), 64'(0));
    reset = 1'b1;
    idle(2);
    acc0 = acc_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    send_pkt(8'h01, 32'h1234_5678);
    idle(3);
    check("t6_accepts", 64'(acc_cnt - acc0), 64'(1));
    check("t6_opcode", 64'(last_op), 64'(8'h01));
    check("t6_data", 64'(last_data), 64'(32'h1234_5678));
    check("t6_frame_err", 64'(fe_cnt - fe0), 64'(0));
    check("t6_overrun", 64'(ov_cnt - ov0), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
